// File: rtl/brcfwd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : brcfwd_pkg
// Brief   : Shared types and constants for the ID-stage branch forwarding unit.
// Revision: 1.0
// ============================================================================
`ifndef W_DATA
`define W_DATA 32
`endif

package brcfwd_pkg;

   localparam int SLOT_AW = 5;
   localparam logic [SLOT_AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic       valid;
      logic [4:0] waddr;
      logic       is_load;
   } fwd_slot_t;

   localparam fwd_slot_t SLOT_EMPTY = '{valid: 1'b0, waddr: REG_ZERO, is_load: 1'b0};

   // $0 is hardwired, so a writer targeting it never supplies a value.
   function automatic logic slot_hit(input fwd_slot_t s, input logic [4:0] op);
      return s.valid && (s.waddr == op) && (op != REG_ZERO);
   endfunction

endpackage

`default_nettype wire

// File: rtl/brcfwd_fwd_pick.sv
`default_nettype none
// ============================================================================
// Module  : fwd_pick
// Brief   : Per-operand lookup over the EX/MEM/WB tracker, youngest slot wins.
// Revision: 1.0
// ============================================================================
module fwd_pick
   import brcfwd_pkg::*;
#(
   parameter int DATA_W = `W_DATA
) (
   input  logic [4:0]        operand_i,
   input  logic              use_i,
   input  fwd_slot_t         slot_ex_i,
   input  fwd_slot_t         slot_mem_i,
   input  fwd_slot_t         slot_wb_i,
   input  logic [DATA_W-1:0] mem_result_i,
   input  logic [DATA_W-1:0] wb_result_i,
   output logic              fwd_o,
   output logic [DATA_W-1:0] data_o,
   output logic              stall_o
);

   logic w_hit_ex;
   logic w_hit_mem;
   logic w_hit_wb;

   assign w_hit_ex  = slot_hit(slot_ex_i,  operand_i);
   assign w_hit_mem = slot_hit(slot_mem_i, operand_i);
   assign w_hit_wb  = slot_hit(slot_wb_i,  operand_i);

   // A younger hit masks older ones even when it can only stall.
   always_comb begin
      fwd_o   = 1'b0;
      data_o  = '0;
      stall_o = 1'b0;
      if (use_i) begin
         if (w_hit_ex) begin
            stall_o = 1'b1;
         end else if (w_hit_mem) begin
            if (slot_mem_i.is_load) begin
               stall_o = 1'b1;
            end else begin
               fwd_o  = 1'b1;
               data_o = mem_result_i;
            end
         end else if (w_hit_wb) begin
            fwd_o  = 1'b1;
            data_o = wb_result_i;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/brcfwd.sv
`default_nettype none
// ============================================================================
// Module  : brcfwd
// Brief   : ID-stage branch operand forwarding with a private EX/MEM/WB tracker.
// Revision: 1.0
// ============================================================================
module brcfwd
   import brcfwd_pkg::*;
#(
   parameter int DATA_W = `W_DATA,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_wen,
   input  logic [REG_AW-1:0] id_waddr,
   input  logic              id_is_load,
   input  logic              pipe_hold,
   input  logic              flush,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [DATA_W-1:0] wb_result,
   output logic              forward_rs,
   output logic              forward_rt,
   output logic [DATA_W-1:0] forward_rs_data,
   output logic [DATA_W-1:0] forward_rt_data,
   output logic              brc_stall
);

   fwd_slot_t ex_q, mem_q, wb_q;
   fwd_slot_t ex_d, mem_d, wb_d;
   logic      w_stall_rs;
   logic      w_stall_rt;

   fwd_pick #(.DATA_W(DATA_W)) u_pick_rs (
      .operand_i    (id_rs),
      .use_i        (id_use_rs),
      .slot_ex_i    (ex_q),
      .slot_mem_i   (mem_q),
      .slot_wb_i    (wb_q),
      .mem_result_i (mem_result),
      .wb_result_i  (wb_result),
      .fwd_o        (forward_rs),
      .data_o       (forward_rs_data),
      .stall_o      (w_stall_rs)
   );

   fwd_pick #(.DATA_W(DATA_W)) u_pick_rt (
      .operand_i    (id_rt),
      .use_i        (id_use_rt),
      .slot_ex_i    (ex_q),
      .slot_mem_i   (mem_q),
      .slot_wb_i    (wb_q),
      .mem_result_i (mem_result),
      .wb_result_i  (wb_result),
      .fwd_o        (forward_rt),
      .data_o       (forward_rt_data),
      .stall_o      (w_stall_rt)
   );

   assign brc_stall = w_stall_rs | w_stall_rt;

   // A stalled or squashed ID instruction enters EX as a bubble.
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!pipe_hold) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (brc_stall || flush) begin
            ex_d = SLOT_EMPTY;
         end else begin
            ex_d.valid   = id_wen && (id_waddr != REG_ZERO);
            ex_d.waddr   = id_waddr;
            ex_d.is_load = id_is_load;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= SLOT_EMPTY;
         mem_q <= SLOT_EMPTY;
         wb_q  <= SLOT_EMPTY;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_brcfwd.sv
`default_nettype none
// ============================================================================
// Module  : tb_brcfwd
// Brief   : Scoreboard bench for brcfwd with an in-flight writer reference model.
// Revision: 1.0
// ============================================================================
module tb_brcfwd;
   import brcfwd_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt, id_waddr;
   logic        id_use_rs, id_use_rt, id_wen, id_is_load, pipe_hold, flush;
   logic [31:0] mem_result, wb_result;
   logic        forward_rs, forward_rt, brc_stall;
   logic [31:0] forward_rs_data, forward_rt_data;

   always #5 clk = ~clk;

   brcfwd #(.DATA_W(32), .REG_AW(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_use_rs       (id_use_rs),
      .id_use_rt       (id_use_rt),
      .id_wen          (id_wen),
      .id_waddr        (id_waddr),
      .id_is_load      (id_is_load),
      .pipe_hold       (pipe_hold),
      .flush           (flush),
      .mem_result      (mem_result),
      .wb_result       (wb_result),
      .forward_rs      (forward_rs),
      .forward_rt      (forward_rt),
      .forward_rs_data (forward_rs_data),
      .forward_rt_data (forward_rt_data),
      .brc_stall       (brc_stall)
   );

   typedef struct {
      bit          rst;
      bit [4:0]    rs, rt;
      bit          use_rs, use_rt, wen;
      bit [4:0]    waddr;
      bit          is_load, hold, flush;
      bit [31:0]   mem, wb;
   } stim_t;

   typedef struct {
      bit        stall, frs, frt;
      bit [31:0] drs, drt;
   } exp_t;

   typedef struct {
      bit writes;
      int dst;
      bit load;
   } writer_t;

   exp_t    sb_q[$];
   writer_t inflight[$];   // [0] youngest (EX) .. [2] oldest (WB)
   stim_t   cur;
   bit      cur_stall;
   int      n_checks = 0;
   int      n_fail   = 0;

   // Reference: youngest in-flight writer of the register decides the outcome.
   function automatic void ref_op(input int op, input bit use_it, input stim_t s,
                                  output bit st, output bit fw, output bit [31:0] d);
      st = 0; fw = 0; d = 0;
      if (!use_it || op == 0) return;
      for (int age = 0; age < 3; age++) begin
         if (inflight[age].writes && inflight[age].dst == op) begin
            if (age == 0 || (age == 1 && inflight[age].load)) st = 1;
            else begin
               fw = 1;
               d  = (age == 1) ? s.mem : s.wb;
            end
            return;
         end
      end
   endfunction

   task automatic model_advance(input stim_t s, input bit stalled);
      writer_t nw;
      if (s.rst) begin
         foreach (inflight[i]) inflight[i] = '{writes: 0, dst: 0, load: 0};
      end else if (!s.hold) begin
         nw.writes = s.wen && !stalled && !s.flush;
         nw.dst    = int'(s.waddr);
         nw.load   = s.is_load;
         void'(inflight.pop_back());
         inflight.push_front(nw);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.rst = 0; s.rs = 0; s.rt = 0; s.use_rs = 0; s.use_rt = 0; s.wen = 0;
      s.waddr = 0; s.is_load = 0; s.hold = 0; s.flush = 0;
      s.mem = 32'h0; s.wb = 32'h0;
      return s;
   endfunction

   function automatic stim_t wr(input int r, input bit ld);
      stim_t s = idle();
      s.wen = 1; s.waddr = 5'(r); s.is_load = ld;
      return s;
   endfunction

   function automatic stim_t br(input int a, input int b, input bit [31:0] m, input bit [31:0] w);
      stim_t s = idle();
      s.rs = 5'(a); s.rt = 5'(b); s.use_rs = 1; s.use_rt = 1; s.mem = m; s.wb = w;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      exp_t e;
      @(posedge clk);
      model_advance(cur, cur_stall);
      #1;
      rst = s.rst; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
      id_wen = s.wen; id_waddr = s.waddr; id_is_load = s.is_load; pipe_hold = s.hold;
      flush = s.flush; mem_result = s.mem; wb_result = s.wb;
      cur = s;
      ref_op(int'(s.rs), s.use_rs, s, e.stall, e.frs, e.drs);
      begin
         bit st_rt;
         ref_op(int'(s.rt), s.use_rt, s, st_rt, e.frt, e.drt);
         e.stall = e.stall | st_rt;
      end
      cur_stall = e.stall;
      sb_q.push_back(e);
   endtask

   task automatic chk(input string name, input bit [31:0] act, input bit [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: outputs are combinational, so every cycle presents one response.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("brc_stall", 32'(brc_stall), 32'(e.stall));
         if (!e.stall) begin
            chk("forward_rs",      32'(forward_rs), 32'(e.frs));
            chk("forward_rt",      32'(forward_rt), 32'(e.frt));
            chk("forward_rs_data", forward_rs_data, e.drs);
            chk("forward_rt_data", forward_rt_data, e.drt);
         end
      end
   end

   initial begin
      stim_t s;
      rst = 1; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_wen = 0;
      id_waddr = 0; id_is_load = 0; pipe_hold = 0; flush = 0; mem_result = 0; wb_result = 0;
      for (int i = 0; i < 3; i++) inflight.push_back('{writes: 0, dst: 0, load: 0});
      cur = idle(); cur.rst = 1; cur_stall = 0;

      s = idle(); s.rst = 1;
      apply(s); apply(s);
      apply(br(3, 3, 32'h11, 32'h22));

      // ALU then branch
      apply(wr(3, 0));
      apply(br(3, 0, 32'h12, 32'h0));
      apply(br(3, 0, 32'h12, 32'h0));

      // load-use
      apply(wr(5, 1));
      repeat (3) apply(br(5, 6, 32'h0, 32'hCAFE));

      // priority MEM over WB
      apply(wr(7, 0)); apply(wr(7, 0)); apply(idle());
      apply(br(7, 7, 32'hA, 32'hB));

      // register zero
      apply(wr(0, 0)); apply(wr(0, 1)); apply(wr(0, 0));
      apply(br(0, 0, 32'h5, 32'h6));

      // pipe_hold with a load in MEM
      apply(wr(4, 1)); apply(idle());
      s = br(4, 0, 32'h0, 32'h44); s.hold = 1;
      repeat (3) apply(s);
      repeat (2) apply(br(4, 0, 32'h0, 32'h44));

      // flush squashes the writer
      s = wr(6, 0); s.flush = 1;
      apply(s);
      apply(br(6, 6, 32'h66, 32'h67));

      // reset during a stall
      apply(wr(9, 0));
      s = br(9, 0, 32'h99, 32'h98); s.rst = 1;
      apply(s);
      apply(br(9, 0, 32'h99, 32'h98));
      apply(br(9, 9, 32'h99, 32'h98));

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         s = idle();
         s.rst     = ($urandom_range(0, 99) == 0);
         s.rs      = 5'($urandom_range(0, 7));
         s.rt      = 5'($urandom_range(0, 7));
         s.use_rs  = $urandom_range(0, 1) == 1;
         s.use_rt  = $urandom_range(0, 1) == 1;
         s.wen     = $urandom_range(0, 3) != 0;
         s.waddr   = 5'($urandom_range(0, 7));
         s.is_load = $urandom_range(0, 2) == 0;
         s.hold    = $urandom_range(0, 7) == 0;
         s.flush   = $urandom_range(0, 9) == 0;
         s.mem     = $urandom;
         s.wb      = $urandom;
         apply(s);
      end

      repeat (3) @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/brcfwd.md
Name: brcfwd

Overview:
- Producer side of the ID-stage branch operand forwarding interface. Generates forward_rs/forward_rt, their data, and a branch stall for the branch operand mux in ID.
- Keeps its own 3-slot tracker (EX, MEM, WB) of in-flight register writers. The tracker advances with the pipeline, so the ID branch compare always sees the youngest pending value of rs/rt.
- Sits in ID beside the hazard logic. Its outputs feed the branch operand mux directly.

Parameters:
- DATA_W, 32, width of `W_DATA register values.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_rs  in  REG_AW  rs address of the instruction in ID.
- id_rt  in  REG_AW  rt address of the instruction in ID.
- id_use_rs  in  1  ID instruction is a branch that reads rs.
- id_use_rt  in  1  ID instruction is a branch that reads rt.
- id_wen  in  1  ID instruction writes a GPR.
- id_waddr  in  REG_AW  destination register of the ID instruction.
- id_is_load  in  1  ID instruction is a load.
- pipe_hold  in  1  global freeze (cache miss etc.); tracker holds.
- flush  in  1  ID instruction squashed; EX slot gets a bubble.
- mem_result  in  DATA_W  ALU result of the instruction in MEM.
- wb_result  in  DATA_W  final write data of the instruction in WB.
- forward_rs  out  1  use forward_rs_data instead of the regfile rs.
- forward_rt  out  1  use forward_rt_data instead of the regfile rt.
- forward_rs_data  out  DATA_W  forwarded rs value.
- forward_rt_data  out  DATA_W  forwarded rt value.
- brc_stall  out  1  ID must stall; branch operand not yet available.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Tracker slot contents: valid, waddr, is_load. Slots are EX, MEM, WB.
- Reset: all slots valid=0. All outputs are therefore 0: forward_* = 0, data = 0, brc_stall = 0.
- Outputs are combinational from the tracker state and the ID/MEM/WB inputs, with zero latency. The tracker updates one cycle after the ID instruction is accepted.
- Slot match: valid && waddr == operand && operand != 0. Register $0 never matches.
- Per operand, checked only when id_use_x=1; otherwise forward_x=0 and data=0.
  - Priority is youngest first: EX, then MEM, then WB.
  - EX match: stall, since the ALU value is not ready in time for the ID compare.
  - MEM match with is_load=1: stall.
  - MEM match with is_load=0: forward, data = mem_result.
  - WB match: forward, data = wb_result.
  - No match: forward=0, data=0.
  - Older matches are ignored once a younger slot matches, including when that younger match stalls.
- brc_stall = stall_rs | stall_rt. While brc_stall=1, forward_x may be 1, but the consumer ignores it.
- Tracker update, evaluated in this order:
  - rst: clear all slots.
  - pipe_hold: all slots hold. pipe_hold takes precedence over flush and brc_stall.
  - Otherwise:
    - WB <= MEM.
    - MEM <= EX.
    - EX <= bubble (valid=0) if brc_stall or flush.
    - Else EX <= {id_wen && id_waddr != 0, id_waddr, id_is_load}.
- A stall inserts exactly one bubble per cycle. A load-use on a branch therefore takes 2 stall cycles (load in EX, then load in MEM) before the value is forwarded from WB.
- Simultaneous rs == rt: both outputs are identical.
- Reset mid-stall clears brc_stall on the next cycle.

Decomposition:
- Package includes:
  - `W_DATA, already present.
  - typedef fwd_slot_t {logic valid; logic [4:0] waddr; logic is_load;}.
  - Constant REG_ZERO = 5'd0.
- Sub-module fwd_pick:
  - Per-operand lookup with inputs operand, use, three slots, mem_result, wb_result.
  - Outputs fwd, data, stall.
  - Instantiated twice, once for rs and once for rt.

Test Plan:
- ALU then branch: issue addu $3 (id_wen=1, waddr=3), then beq $3,$0 the next cycle.
  - Cycle 1: brc_stall=1.
  - Next cycle, with mem_result=0x12: forward_rs=1, data=0x12, brc_stall=0.
- Load-use: lw $5, then bne $5,$6.
  - 2 cycles of brc_stall=1.
  - Third cycle, with wb_result=0xCAFE: forward_rs=1, data=0xCAFE.
  - forward_rt=0.
- Priority: $7 is in MEM (non-load, mem_result=0xA) and also in WB (wb_result=0xB); branch reads $7 -> forward data=0xA.
- $0: a writer with waddr=0 in any slot, branch reads $0 -> forward_rs=0, brc_stall=0.
- pipe_hold: load $4 in MEM, hold asserted for 3 cycles.
  - brc_stall stays 1 for all 3 cycles and the tracker is unchanged.
  - After release, stall continues 1 more cycle, then forwards from WB.
- Reset: rst asserted during a stall -> the next cycle has all outputs 0 and the tracker empty. A subsequent branch on the same register forwards nothing.
